// File: rtl/bidi_message_queue_dev_if.sv
// Client-facing message queue bundle: 32-bit outbound and inbound streams
// with valid/ready handshakes.
interface bidi_message_queue_if;
  logic        outbound_valid;
  logic [31:0] outbound_data;
  logic        outbound_ready;
  logic        inbound_valid;
  logic [31:0] inbound_data;
  logic        inbound_ready;

  modport msg_q (
    output outbound_valid, outbound_data, inbound_ready,
    input  outbound_ready, inbound_valid, inbound_data
  );

  modport client (
    input  outbound_valid, outbound_data, inbound_ready,
    output outbound_ready, inbound_valid, inbound_data
  );
endinterface

// File: rtl/bidi_message_queue_dev.sv
// Device-side message queue endpoint: an outbound FIFO (local write -> client)
// and an inbound FIFO (client -> local read), each first-word fall-through.
module bidi_message_queue_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_valid,
  input  logic [31:0]              push_data,
  output logic                     push_ready,
  output logic                     pop_valid,
  output logic [31:0]              pop_data,
  input  logic                     pop_ready,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  // Ready/valid come only from rst and the registered count, never from the
  // opposite side's handshake, so a pop while full cannot admit a push.
  assign push_ready = !rst && (count != CW'(DEPTH));
  assign pop_valid  = !rst && (count != '0);
  assign pop_data   = mem[rd_ptr];
  assign push       = push_valid && push_ready;
  assign pop        = pop_valid && pop_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module bidi_message_queue_dev #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  bidi_message_queue_if.msg_q      queue_if,
  input  logic                     wr_valid,
  input  logic [31:0]              wr_data,
  output logic                     wr_ready,
  output logic                     rd_valid,
  output logic [31:0]              rd_data,
  input  logic                     rd_ready,
  output logic [$clog2(DEPTH):0]   outbound_count,
  output logic [$clog2(DEPTH):0]   inbound_count
);
  bidi_message_queue_fifo #(.DEPTH(DEPTH)) outbound_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_valid (wr_valid),
    .push_data  (wr_data),
    .push_ready (wr_ready),
    .pop_valid  (queue_if.outbound_valid),
    .pop_data   (queue_if.outbound_data),
    .pop_ready  (queue_if.outbound_ready),
    .count      (outbound_count)
  );

  bidi_message_queue_fifo #(.DEPTH(DEPTH)) inbound_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_valid (queue_if.inbound_valid),
    .push_data  (queue_if.inbound_data),
    .push_ready (queue_if.inbound_ready),
    .pop_valid  (rd_valid),
    .pop_data   (rd_data),
    .pop_ready  (rd_ready),
    .count      (inbound_count)
  );
endmodule
